div_result_fifo: RTL and testbench
==================================

// Module: div_result_fifo
// PURPOSE
//   Downstream stage of the 8-bit unsigned divider. Each cycle with in_valid=1 and in_ready=1 it
//   captures one divider transaction: dividend, divisor and the divider's packed {quotient[3:0],
//   remainder[3:0]} byte. It flags divide-by-zero and 4-bit quotient overflow, then buffers the
//   result in a show-ahead FIFO. Results leave over a valid/ready interface.
// PARAMETERS
//   DEPTH   4   FIFO entries; power of two, >= 2
//   CNT_W   8   width of the saturating error counter
// PORTS
//   clk          in   1      clock; all logic updates on the rising edge
//   rst          in   1      synchronous reset, active-high
//   in_valid     in   1      transaction present on in_* this cycle
//   in_ready     out  1      stage can accept; equals !full
//   in_dividend  in   8      dividend that was applied to the divider
//   in_divisor   in   8      divisor that was applied to the divider
//   in_result    in   8      divider output {quotient[3:0], remainder[3:0]}
//   out_valid    out  1      head entry valid (FIFO non-empty)
//   out_ready    in   1      consumer takes the head entry this cycle
//   out_data     out  8      head entry result byte
//   out_dz       out  1      head entry: divisor was zero
//   out_ovf      out  1      head entry: true quotient > 15
//   level        out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
//   err_count    out  CNT_W  accepted entries with dz|ovf; saturates at all-ones
// BEHAVIOUR
//   - push = in_valid & in_ready. pop = out_valid & out_ready.
//   - in_ready = (level != DEPTH). It does not depend on out_ready, so there is no full-bypass.
//   - Flags are computed combinationally at push:
//       dz  = (in_divisor == 0)
//       ovf = !dz && ({4'b0,in_dividend} >= {in_divisor,4'b0})   (12-bit compare)
//   - Stored byte = dz ? 8'hFF : in_result. On ovf, in_result is stored unmodified (truncated quotient).
//   - Entry = {data[7:0], dz, ovf}, written at the write pointer. Pointers wrap modulo DEPTH.
//   - Show-ahead output: out_data, out_dz and out_ovf always reflect the entry at the read pointer.
//     They are don't-care while out_valid=0.
//   - Latency: an entry pushed in cycle N gives out_valid=1 from cycle N+1 when the FIFO was empty.
//   - Level update: push only -> +1; pop only -> -1; push and pop together -> unchanged.
//     Both pointers advance on the simultaneous case.
//   - Empty: pop cannot occur because out_valid=0. out_ready is ignored.
//   - Full: in_ready=0, so in_valid is ignored and nothing is stored. A pop while full drops level
//     to DEPTH-1. in_ready returns next cycle.
//   - err_count += 1 on each push with dz|ovf. It holds at 2^CNT_W-1.
//   - Reset (any cycle, including mid-stream): pointers=0, level=0, out_valid=0, in_ready=1 in the
//     cycle after reset, err_count=0. Entries are discarded; storage contents are not cleared.
//   - While rst=1: in_ready=0 and no push or pop is performed.
// TESTING
//   1. rst=1 for 2 cycles -> level=0, out_valid=0, err_count=0; in_ready=1 after release.
//   2. push 100/7, result 8'hE2 -> next cycle out_valid=1, out_data=E2, dz=0, ovf=0; pop -> level=0.
//   3. push 255/3, result 8'h50 -> out_data=50, ovf=1, dz=0, err_count=1.
//      Push 200/15, result 8'hD5 -> ovf=0.
//   4. push 42/0, any result -> out_data=FF, dz=1, ovf=0, err_count increments.
//   5. out_ready=0, push 5 entries back-to-back -> in_ready=0 after the 4th, level=4,
//      5th held by source. Draining gives the 4 entries in FIFO order.
//   6. level=2, push+pop same cycle -> level stays 2, order preserved.
//      Assert rst mid-stream -> level=0 next cycle.

Source files
------------

// File: rtl/div_result_fifo.sv
// div_result_fifo: flags divider results (divide-by-zero, quotient overflow) and buffers them in a show-ahead FIFO
module div_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_dividend,
    input  logic [7:0]               in_divisor,
    input  logic [7:0]               in_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_dz,
    output logic                     out_ovf,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [9:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic dz, ovf, push, pop;
    always_comb begin
        dz = in_divisor == 8'd0;
        ovf = !dz && ({4'b0, in_dividend} >= {in_divisor, 4'b0});
        in_ready = !rst && level != FULL;
        out_valid = level != '0;
        push = in_valid && in_ready;
        pop = out_valid && out_ready && !rst;
        {out_data, out_dz, out_ovf} = mem[rp];
    end
    always_ff @(posedge clk)
        if (push) mem[wp] <= {dz ? 8'hFF : in_result, dz, ovf};
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
            err_count <= '0;
        end else begin
            wp <= wp + AW'(push);
            rp <= rp + AW'(pop);
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
            if (push && (dz || ovf) && err_count != '1) err_count <= err_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_div_result_fifo.sv
// tb_div_result_fifo: randomized scoreboard bench against a queue-based model of the result FIFO
module tb_div_result_fifo;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    logic clk = 0, rst = 1;
    logic in_valid = 0, out_ready = 0;
    logic [7:0] in_dividend = 0, in_divisor = 0, in_result = 0;
    logic in_ready, out_valid, out_dz, out_ovf;
    logic [7:0] out_data;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0] err_count;
    int vectors = 0, miscompares = 0;
    logic [9:0] exp_q[$];
    logic [9:0] e;
    int merr = 0;
    bit full, mdz, movf;

    div_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor), .in_result(in_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dz(out_dz), .out_ovf(out_ovf), .level(level), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)", name, $time, act, act, exp, exp);
        end
    endtask

    // monitor and reference model: inputs are stable at the falling edge, so the upcoming
    // rising edge's push/pop are decided here from the model's occupancy
    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready_in_reset", int'(in_ready), 0);
            exp_q.delete();
            merr = 0;
        end else begin
            full = exp_q.size() == DEPTH;
            chk("level", int'(level), exp_q.size());
            chk("in_ready", int'(in_ready), int'(!full));
            chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            chk("err_count", int'(err_count), merr);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pop_underflow at %0t: out_valid=1 with no expected entry", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", int'(out_data), int'(e[9:2]));
                    chk("out_dz", int'(out_dz), int'(e[1]));
                    chk("out_ovf", int'(out_ovf), int'(e[0]));
                end
            end
            if (in_valid && !full) begin
                mdz = in_divisor == 0;
                movf = !mdz && (int'(in_dividend) / int'(in_divisor)) > 15;
                exp_q.push_back({mdz ? 8'hFF : in_result, mdz, movf});
                if ((mdz || movf) && merr < (1 << CNT_W) - 1) merr++;
            end
        end
    end

    task automatic drive(bit v, int dd, int ds, int r, bit ordy);
        in_valid = v;
        in_dividend = 8'(dd);
        in_divisor = 8'(ds);
        in_result = 8'(r);
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1;
        repeat (2) drive(0, 0, 0, 0, 0);
        rst = 0;
        drive(1, 100, 7, 'hE2, 0);
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 1, 0, 0);
        drive(1, 255, 3, 'h50, 0);
        drive(1, 200, 15, 'hD5, 0);
        drive(1, 42, 0, 'h33, 0);
        repeat (4) drive(0, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, i * 20 + 3, i + 1, $urandom, 0);
        drive(1, 99, 5, 'hA5, 0);
        repeat (6) drive(0, 0, 1, 0, 1);
        drive(1, 17, 2, 'h11, 0);
        drive(1, 34, 3, 'h22, 0);
        for (int i = 0; i < 3; i++) drive(1, 50 + i, 4, $urandom, 1);
        rst = 1;
        drive(1, 60, 4, 'h77, 1);
        rst = 0;
        drive(0, 0, 1, 0, 0);
        repeat (400) drive($urandom_range(0, 1), $urandom,
                           ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255),
                           $urandom, $urandom_range(0, 1));
        repeat (300) drive(1, $urandom, 0, 0, 1);
        repeat (6) drive(0, 0, 1, 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
